// File: rtl/connect_pkg.sv
// connect_pkg: definitions shared by both ends of the PE <-> NoC credit link.
// Holds the default link sizing and helper functions that derive the flit
// layout. The sending PE and pe_flit_sink both use it, so the two ends always
// agree on where each field sits.
//
// Flit layout, MSB to LSB: {valid, tail, dest, vc, data}.
// Credit layout, MSB to LSB: {valid, vc}.
package connect_pkg;

    localparam int DEF_NUM_VCS    = 2;
    localparam int DEF_DEST_BITS  = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BUF_DEPTH  = 8;

    // A single-VC link still carries a 1-bit vc field, so the layout does
    // not change shape with NUM_VCS.
    function automatic int vc_bits_f(input int num_vcs);
        return (num_vcs > 1) ? $clog2(num_vcs) : 1;
    endfunction

    function automatic int flit_w_f(input int dest_bits, input int vc_bits,
                                    input int data_width);
        return 2 + dest_bits + vc_bits + data_width;
    endfunction

    // Field offsets. The data field starts at bit 0.
    function automatic int vc_lsb_f(input int data_width);
        return data_width;
    endfunction

    function automatic int dest_lsb_f(input int vc_bits, input int data_width);
        return data_width + vc_bits;
    endfunction

    function automatic int tail_idx_f(input int dest_bits, input int vc_bits,
                                      input int data_width);
        return data_width + vc_bits + dest_bits;
    endfunction

    function automatic int valid_idx_f(input int dest_bits, input int vc_bits,
                                       input int data_width);
        return data_width + vc_bits + dest_bits + 1;
    endfunction

endpackage

// File: rtl/pe_vc_fifo.sv
// pe_vc_fifo: single-clock synchronous FIFO that holds one VC's flits.
// The pointers are one bit wider than the address. Equal pointers mean the
// FIFO is empty. Pointers that differ only in the extra MSB mean it is full.
// Reads are show-ahead: rd_data always shows the current head.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (clears the pointers)
//   wr_en      : push wr_data. Ignored while full.
//   rd_en      : pop the head. Ignored while empty.
//   rd_data    : head entry, valid whenever !empty
//   full/empty : occupancy status
module pe_vc_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8      // power of 2, at least 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // The storage array has no reset. Entries are only ever read after a write.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // Because DEPTH is a power of 2, the natural wrap of the pointers is
    // modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/pe_flit_sink.sv
// pe_flit_sink: receive-side endpoint of the credit-based PE <-> NoC link.
// Incoming flits go into a FIFO for their VC. A round-robin arbiter across
// the VCs presents one head flit to the local consumer over valid/ready.
// Every flit the consumer takes returns one credit upstream on the next
// cycle. Protocol errors set sticky flags. Receive counters count accepted
// flits and packets.
//
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   flit_in           : {valid, tail, dest, vc, data} from the router
//   credit_out        : {valid, vc}, one pulse per consumed flit
//   deq_valid/ready   : consumer handshake
//   deq_data/vc/tail  : presented flit. Held stable while stalled.
//   err_overflow      : sticky. A flit arrived for a full VC.
//   err_misroute      : sticky. Wrong dest, or vc out of range.
//   rx_flit_cnt/pkt_cnt : flits and tail flits accepted (wrapping)
module pe_flit_sink
    import connect_pkg::*;
#(
    parameter int NUM_VCS    = DEF_NUM_VCS,
    parameter int VC_BITS    = vc_bits_f(NUM_VCS),
    parameter int DEST_BITS  = DEF_DEST_BITS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int MY_ID      = 10,
    parameter int FLIT_W     = flit_w_f(DEST_BITS, VC_BITS, DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLIT_W-1:0]     flit_in,
    output logic [VC_BITS:0]      credit_out,
    output logic                  deq_valid,
    input  logic                  deq_ready,
    output logic [DATA_WIDTH-1:0] deq_data,
    output logic [VC_BITS-1:0]    deq_vc,
    output logic                  deq_tail,
    output logic                  err_overflow,
    output logic                  err_misroute,
    output logic [31:0]           rx_flit_cnt,
    output logic [31:0]           rx_pkt_cnt
);
    localparam int VC_LSB    = vc_lsb_f(DATA_WIDTH);
    localparam int DEST_LSB  = dest_lsb_f(VC_BITS, DATA_WIDTH);
    localparam int TAIL_IDX  = tail_idx_f(DEST_BITS, VC_BITS, DATA_WIDTH);
    localparam int VALID_IDX = valid_idx_f(DEST_BITS, VC_BITS, DATA_WIDTH);

    // Incoming flit fields
    logic                  in_vld, in_tail, vc_ok, bad_dest;
    logic [DEST_BITS-1:0]  in_dest;
    logic [VC_BITS-1:0]    in_vc;
    logic [DATA_WIDTH-1:0] in_data;

    assign in_vld   = flit_in[VALID_IDX];
    assign in_tail  = flit_in[TAIL_IDX];
    assign in_dest  = flit_in[DEST_LSB +: DEST_BITS];
    assign in_vc    = flit_in[VC_LSB +: VC_BITS];
    assign in_data  = flit_in[DATA_WIDTH-1:0];
    assign vc_ok    = (int'(in_vc) < NUM_VCS);
    assign bad_dest = (in_dest != DEST_BITS'(MY_ID));

    // Per-VC FIFO bank
    logic [NUM_VCS-1:0]             wr_en, rd_en, ovf_hit, fifo_full, fifo_empty;
    logic [NUM_VCS-1:0][DATA_WIDTH:0] fifo_rd;   // {tail, data}

    // Arbiter state
    logic                  hs, held;
    logic [VC_BITS-1:0]    rr_ptr, held_vc, scan_vc, sel_vc, rr_nxt;

    assign hs = deq_valid && deq_ready;

    for (genvar g = 0; g < NUM_VCS; g++) begin : g_vc
        // Fullness is checked before this cycle's pop. The sender had no
        // credit for this slot, so a same-cycle dequeue does not rescue the flit.
        assign wr_en[g]   = in_vld && (int'(in_vc) == g) && !fifo_full[g];
        assign ovf_hit[g] = in_vld && (int'(in_vc) == g) && fifo_full[g];
        assign rd_en[g]   = hs && (int'(sel_vc) == g);

        pe_vc_fifo #(
            .WIDTH (DATA_WIDTH + 1),
            .DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[g]),
            .wr_data ({in_tail, in_data}),
            .rd_en   (rd_en[g]),
            .rd_data (fifo_rd[g]),
            .full    (fifo_full[g]),
            .empty   (fifo_empty[g])
        );
    end

    // Round-robin scan. The loop runs downward and each hit overwrites the
    // last, so the closest non-empty VC at or after rr_ptr wins. A stalled
    // presentation stays locked on held_vc until its handshake. That FIFO's
    // head cannot move in the meantime, because only a handshake pops it.
    always_comb begin
        scan_vc = rr_ptr;
        for (int i = NUM_VCS - 1; i >= 0; i--) begin
            if (!fifo_empty[(int'(rr_ptr) + i) % NUM_VCS])
                scan_vc = VC_BITS'((int'(rr_ptr) + i) % NUM_VCS);
        end
        sel_vc    = held ? held_vc : scan_vc;
        deq_valid = !fifo_empty[sel_vc];
        deq_vc    = sel_vc;
        deq_data  = fifo_rd[sel_vc][DATA_WIDTH-1:0];
        deq_tail  = fifo_rd[sel_vc][DATA_WIDTH];
        rr_nxt    = VC_BITS'((int'(sel_vc) + 1) % NUM_VCS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            held         <= 1'b0;
            held_vc      <= '0;
            credit_out   <= '0;
            err_overflow <= 1'b0;
            err_misroute <= 1'b0;
            rx_flit_cnt  <= '0;
            rx_pkt_cnt   <= '0;
        end else begin
            held    <= deq_valid && !deq_ready;
            held_vc <= sel_vc;
            if (hs) rr_ptr <= rr_nxt;
            // At most one handshake per cycle, so one credit register is enough.
            credit_out <= hs ? {1'b1, sel_vc} : '0;
            if (in_vld && (!vc_ok || bad_dest)) err_misroute <= 1'b1;
            if (|ovf_hit) err_overflow <= 1'b1;
            if (|wr_en) begin
                rx_flit_cnt <= rx_flit_cnt + 32'd1;
                if (in_tail) rx_pkt_cnt <= rx_pkt_cnt + 32'd1;
            end
        end
    end

endmodule
